pcs_tx_am_bip: RTL

Multi-lane PCS transmit back-end with valid/ready flow control on both sides. Takes encoded, unscrambled 66b blocks for all lanes and scrambles the payload. Periodically inserts per-lane alignment markers carrying a running BIP3/BIP7, then hands registered blocks to the gearbox. It replaces the fixed non-blocking transmit path with lane count, marker period and mode set by parameters, plus true back-pressure from the gearbox.

---
 rtl/pcs_pkg.sv | 31 +++
 rtl/pcs_tx_am_bip_bip_calc.sv | 25 ++
 rtl/pcs_tx_am_bip.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS constants: block geometry, alignment-marker encoding and the
// transmit state machine encoding.
package pcs_pkg;

    localparam int PCS_DATA_W  = 64;
    localparam int PCS_HEAD_W  = 2;
    localparam int PCS_BLOCK_W = PCS_DATA_W + PCS_HEAD_W;

    localparam logic [PCS_HEAD_W-1:0] AM_SYNC = 2'b10;

    // Per-lane marker bytes {M2, M1, M0}; M0 sits in the low byte.
    localparam int AM_LANES_MAX = 4;
    localparam logic [AM_LANES_MAX-1:0][23:0] AM_LANE_BYTES = {
        24'h3D79A2,  // lane 3
        24'h9B65C5,  // lane 2
        24'hE6C4F0,  // lane 1
        24'h477690   // lane 0
    };

    typedef enum logic {
        S_DATA = 1'b0,
        S_AM   = 1'b1
    } state_e;

    // Full 66b marker block: payload M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3 above the sync header.
    function automatic logic [PCS_BLOCK_W-1:0] am_block(input logic [23:0] m,
                                                         input logic [7:0]  bip);
        return {~bip, ~m, bip, m, AM_SYNC};
    endfunction

endpackage

// File: rtl/pcs_tx_am_bip_bip_calc.sv
// BIP8 step for one lane: folds one 66b block into the running parity.
module bip_calc
    import pcs_pkg::*;
(
    input  logic [PCS_BLOCK_W-1:0] block_i,
    input  logic [7:0]             bip_i,
    output logic [7:0]             bip_o
);

    // Header bits 0/1 land in BIP bits 3/4; payload bits stride 8 starting at block bit 2.
    always_comb begin
        // NOTE: the output gets a full default before the loop so no path can leave it unassigned (no latch).
        bip_o = bip_i;
        for (int b = 0; b < PCS_BLOCK_W; b++) begin
            if (b == 0) begin
                bip_o[3] = bip_o[3] ^ block_i[b];
            end else if (b == 1) begin
                bip_o[4] = bip_o[4] ^ block_i[b];
            end else begin
                bip_o[3'((b - 2) % 8)] = bip_o[3'((b - 2) % 8)] ^ block_i[b];
            end
        end
    end

endmodule

// File: rtl/pcs_tx_am_bip.sv
// Multi-lane PCS transmit back-end: scrambles 66b blocks, inserts per-lane
// alignment markers carrying BIP, and presents a registered valid/ready output.
module pcs_tx_am_bip
    import pcs_pkg::*;
#(
    parameter int LANE_N  = 4,
    parameter int DATA_W  = 64,
    parameter int HEAD_W  = 2,
    parameter int BLOCK_W = DATA_W + HEAD_W,
    parameter int AM_GAP  = 16383,
    parameter bit IS_10G  = 1'b0
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANE_N*HEAD_W-1:0]  head_i,
    input  logic [LANE_N*DATA_W-1:0]  data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANE_N*BLOCK_W-1:0] data_o,
    output logic                      am_o
);

    localparam int               PAY_W     = LANE_N * DATA_W;
    localparam int               CNT_W     = $clog2(AM_GAP);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(AM_GAP - 1);
    localparam state_e           RST_STATE = IS_10G ? S_DATA : S_AM;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [57:0]               scr_q, scr_d, scr_run;
    logic                      out_valid_q, out_valid_d;
    logic                      am_q, am_d;
    logic [LANE_N*BLOCK_W-1:0] data_q, data_d;
    logic [7:0]                bip_q [LANE_N];
    logic [7:0]                bip_d [LANE_N];
    logic [7:0]                bip_nx [LANE_N];
    logic [PAY_W-1:0]          scr_pay;
    logic [LANE_N*BLOCK_W-1:0] scr_blocks, am_blocks;
    logic                      load, accept;

    // Self-synchronous x^58+x^39+1 scrambler over all payloads, lane 0 bit 0 first.
    always_comb begin
        scr_run = scr_q;
        scr_pay = '0;
        for (int i = 0; i < PAY_W; i++) begin
            scr_pay[i] = data_i[i] ^ scr_run[38] ^ scr_run[57];
            scr_run    = {scr_run[56:0], scr_pay[i]};
        end
    end

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        assign scr_blocks[l*BLOCK_W +: BLOCK_W] =
            {scr_pay[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};

        if (!IS_10G) begin : g_am
            logic [BLOCK_W-1:0] bip_block;
            logic [7:0]         bip_seed;

            assign am_blocks[l*BLOCK_W +: BLOCK_W] = am_block(AM_LANE_BYTES[l], bip_q[l]);
            // A marker restarts the accumulator with its own parity.
            assign bip_block = (state_q == S_AM) ? am_blocks[l*BLOCK_W +: BLOCK_W]
                                                 : scr_blocks[l*BLOCK_W +: BLOCK_W];
            assign bip_seed  = (state_q == S_AM) ? 8'h00 : bip_q[l];

            bip_calc u_bip_calc (
                .block_i (bip_block),
                .bip_i   (bip_seed),
                .bip_o   (bip_nx[l])
            );
        end else begin : g_no_am
            assign am_blocks[l*BLOCK_W +: BLOCK_W] = '0;
            assign bip_nx[l]                       = '0;
        end
    end

    // Handshake, next state and output-register load selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        scr_d       = scr_q;
        out_valid_d = out_valid_q;
        am_d        = am_q;
        data_d      = data_q;
        bip_d       = bip_q;

        load       = ~out_valid_q | out_ready_i;
        in_ready_o = (state_q == S_DATA) & load;
        accept     = in_valid_i & in_ready_o;

        if (state_q == S_AM) begin
            if (load) begin
                data_d      = am_blocks;
                am_d        = 1'b1;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                bip_d       = bip_nx;
                state_d     = S_DATA;
            end
        end else if (accept) begin
            data_d      = scr_blocks;
            am_d        = 1'b0;
            out_valid_d = 1'b1;
            scr_d       = scr_run;
            bip_d       = bip_nx;
            if (!IS_10G) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_AM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset; a held block is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!nreset) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            scr_q       <= '1;
            out_valid_q <= 1'b0;
            am_q        <= 1'b0;
            // NOTE: the block register is reset as well, so the gearbox never sees X even while out_valid_o is low.
            data_q      <= '0;
            bip_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scr_q       <= scr_d;
            out_valid_q <= out_valid_d;
            am_q        <= am_d;
            data_q      <= data_d;
            bip_q       <= bip_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign am_o        = am_q;
    assign data_o      = data_q;

endmodule
